// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: handshake and data bundle for the sequential ALU.
//   master : start, op, lop, rop in; sees busy, done, result, result_hi, zero, div0
//   slave  : the ALU side; drives the status and result signals
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] lop;
  logic [WIDTH-1:0] rop;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div0;

  modport master (
    output start, op, lop, rop,
    input  busy, done, result, result_hi, zero, div0
  );

  modport slave (
    input  start, op, lop, rop,
    output busy, done, result, result_hi, zero, div0
  );
endinterface

// File: rtl/multicycle_alu.sv
// multicycle_alu: sequential ALU (add/sub/sltu/and/or in one cycle, shift-add mulu
// and restoring divu in WIDTH+1 cycles). Operands are latched on an accepted start.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : multicycle_alu_if slave (start/op/lop/rop in; busy/done/result/
//              result_hi/zero/div0 out). done is a one-cycle pulse; results hold
//              until the next done.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_alu_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SLT  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_MULU = 3'b101;
  localparam logic [2:0] OP_DIVU = 3'b110;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             mul_op;
  logic [WIDTH-1:0] opnd;     // mulu: multiplicand; divu: divisor
  logic [WIDTH-1:0] acc_hi;   // mulu: upper partial product; divu: partial remainder
  logic [WIDTH-1:0] acc_lo;   // mulu: multiplier/lower product; divu: dividend/quotient
  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             zero_q, div0_q;

  logic             iter_req, div0_req, last;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
  logic [WIDTH-1:0] step_hi, step_lo;

  assign iter_req = (bus.op == OP_MULU) || ((bus.op == OP_DIVU) && (bus.rop != '0));
  assign div0_req = (bus.op == OP_DIVU) && (bus.rop == '0);
  assign last     = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    simple_res = '0;
    case (bus.op)
      OP_ADD:  simple_res = bus.lop + bus.rop;
      OP_SUB:  simple_res = bus.lop - bus.rop;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, (bus.lop < bus.rop)};
      OP_AND:  simple_res = bus.lop & bus.rop;
      OP_OR:   simple_res = bus.lop | bus.rop;
      default: simple_res = '0;
    endcase
  end

  // One iteration of each algorithm. For divu the subtraction is done at WIDTH bits:
  // when div_ge holds the true difference is below the divisor, so no bits are lost.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[WIDTH-1:0] - opnd;
    if (mul_op) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FINISH: begin
        if (!bus.start)    state_nx = IDLE;
        else if (iter_req) state_nx = RUN;
        else               state_nx = FINISH;
      end
      RUN:     state_nx = last ? FINISH : RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      mul_op   <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (bus.start) begin
            if (iter_req) begin
              mul_op <= (bus.op == OP_MULU);
              opnd   <= (bus.op == OP_MULU) ? bus.lop : bus.rop;
              acc_lo <= (bus.op == OP_MULU) ? bus.rop : bus.lop;
              acc_hi <= '0;
              cnt    <= '0;
            end else if (div0_req) begin
              res_q    <= '1;
              res_hi_q <= bus.lop;
              zero_q   <= 1'b0;
              div0_q   <= 1'b1;
            end else begin
              res_q    <= simple_res;
              res_hi_q <= '0;
              zero_q   <= (simple_res == '0);
              div0_q   <= 1'b0;
            end
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            res_q    <= step_lo;
            res_hi_q <= step_hi;
            zero_q   <= (step_lo == '0);
            div0_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == FINISH);
  assign bus.result    = res_q;
  assign bus.result_hi = res_hi_q;
  assign bus.zero      = zero_q;
  assign bus.div0      = div0_q;

endmodule
